// File: rtl/parity_tally_pkg.sv
// parity_tally_pkg: shared types and constants for the parity_tally frame tally stage.
package parity_tally_pkg;

    // Default number of samples per frame
    localparam int FRAME_LEN_DEF = 16;

    // Width of one sample nibble
    localparam int NIB_W = 4;

    // Frame FSM: collect samples, then present the result until it is taken
    typedef enum logic {
        ACCUM  = 1'b0,
        REPORT = 1'b1
    } state_e;

endpackage : parity_tally_pkg

// File: rtl/run_tracker.sv
// run_tracker: tracks the current run of same-parity samples and the longest
// run seen so far within one frame. The run restarts at 1 on the first sample
// of a frame or when parity flips; idle cycles leave it untouched.
module run_tracker #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             accept_i,
    input  logic             parity_i,
    input  logic             frame_start_i,
    input  logic             clear_i,
    output logic [CNT_W-1:0] run_o,
    output logic [CNT_W-1:0] max_run_o
);

    logic [CNT_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic             parity_q, parity_d;

    // Next run / max-run values from the accept strobe and the previous parity
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no latch is inferred.
        run_d    = run_q;
        max_d    = max_q;
        parity_d = parity_q;
        if (clear_i) begin
            run_d    = '0;
            max_d    = '0;
            parity_d = 1'b0;
        end else if (accept_i) begin
            if (frame_start_i || (parity_i != parity_q)) begin
                run_d = CNT_W'(1);
            end else begin
                run_d = run_q + CNT_W'(1);
            end
            max_d    = (run_d > max_q) ? run_d : max_q;
            parity_d = parity_i;
        end
    end

    // Run state registers, cleared asynchronously on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q    <= '0;
            max_q    <= '0;
            parity_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all flops update together at the edge.
            run_q    <= run_d;
            max_q    <= max_d;
            parity_q <= parity_d;
        end
    end

    assign run_o     = run_q;
    assign max_run_o = max_q;

endmodule : run_tracker

// File: rtl/parity_tally.sv
// parity_tally: counts even/odd nibble samples over a fixed-length frame,
// tracks the longest same-parity run and checks classifier flag consistency,
// then holds the result on a valid/ready handshake until it is taken.
// Optional feature macro: PARITY_TALLY_SUM_EN adds per-parity sample sums.
module parity_tally
    import parity_tally_pkg::*;
#(
    parameter  int FRAME_LEN = FRAME_LEN_DEF,
    localparam int CNT_W     = $clog2(FRAME_LEN + 1),
    localparam int SUM_W     = $clog2(15 * FRAME_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NIB_W-1:0] a,
    input  logic             even,
    input  logic             odd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] even_cnt,
    output logic [CNT_W-1:0] odd_cnt,
    output logic [CNT_W-1:0] max_run,
    output logic             flag_err
`ifdef PARITY_TALLY_SUM_EN
    ,
    output logic [SUM_W-1:0] even_sum,
    output logic [SUM_W-1:0] odd_sum
`endif
);

    state_e           state_q;
    logic [CNT_W-1:0] index_q, index_d;
    logic [CNT_W-1:0] even_cnt_q, even_cnt_d;
    logic [CNT_W-1:0] odd_cnt_q, odd_cnt_d;
    logic             flag_err_q, flag_err_d;

    logic accept;
    logic last_sample;
    logic frame_start;
    logic result_taken;
    logic sample_err;

    // Handshake decode uses registered state only; reset forces ready low
    assign in_ready     = (state_q == ACCUM) && !rst;
    assign out_valid    = (state_q == REPORT);
    assign accept       = in_valid && in_ready;
    assign result_taken = (state_q == REPORT) && out_ready;
    assign last_sample  = (index_q == CNT_W'(FRAME_LEN - 1));
    assign frame_start  = (index_q == '0);
    // Flags must be mutually exclusive and agree with the sample LSB
    assign sample_err   = (even == odd) || (even != ~a[0]);

    // Frame FSM: leave ACCUM on the last accept, leave REPORT when the result is taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
        end else begin
            case (state_q)
                ACCUM:   if (accept && last_sample) state_q <= REPORT;
                REPORT:  if (out_ready)             state_q <= ACCUM;
                default:                            state_q <= ACCUM;
            endcase
        end
    end

    // Next-state counts, index and sticky flag error
    always_comb begin
        even_cnt_d = even_cnt_q;
        odd_cnt_d  = odd_cnt_q;
        index_d    = index_q;
        flag_err_d = flag_err_q;
        if (result_taken) begin
            even_cnt_d = '0;
            odd_cnt_d  = '0;
            index_d    = '0;
            flag_err_d = 1'b0;
        end else if (accept) begin
            if (even) begin
                even_cnt_d = even_cnt_q + CNT_W'(1);
            end else begin
                odd_cnt_d = odd_cnt_q + CNT_W'(1);
            end
            index_d    = index_q + CNT_W'(1);
            flag_err_d = flag_err_q || sample_err;
        end
    end

    // Count, index and flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            even_cnt_q <= '0;
            odd_cnt_q  <= '0;
            index_q    <= '0;
            flag_err_q <= 1'b0;
        end else begin
            even_cnt_q <= even_cnt_d;
            odd_cnt_q  <= odd_cnt_d;
            index_q    <= index_d;
            flag_err_q <= flag_err_d;
        end
    end

    run_tracker #(
        .CNT_W (CNT_W)
    ) u_run_tracker (
        .clk           (clk),
        .rst           (rst),
        .accept_i      (accept),
        .parity_i      (even),
        .frame_start_i (frame_start),
        .clear_i       (result_taken),
        .run_o         (),
        .max_run_o     (max_run)
    );

    assign even_cnt = even_cnt_q;
    assign odd_cnt  = odd_cnt_q;
    assign flag_err = flag_err_q;

`ifdef PARITY_TALLY_SUM_EN
    logic [SUM_W-1:0] even_sum_q, even_sum_d;
    logic [SUM_W-1:0] odd_sum_q, odd_sum_d;

    // Per-parity sums of accepted samples, cleared like the counts
    always_comb begin
        even_sum_d = even_sum_q;
        odd_sum_d  = odd_sum_q;
        if (result_taken) begin
            even_sum_d = '0;
            odd_sum_d  = '0;
        end else if (accept) begin
            if (even) begin
                even_sum_d = even_sum_q + SUM_W'(a);
            end else begin
                odd_sum_d = odd_sum_q + SUM_W'(a);
            end
        end
    end

    // Sum registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            even_sum_q <= '0;
            odd_sum_q  <= '0;
        end else begin
            even_sum_q <= even_sum_d;
            odd_sum_q  <= odd_sum_d;
        end
    end

    assign even_sum = even_sum_q;
    assign odd_sum  = odd_sum_q;
`endif

endmodule : parity_tally

// File: tb/tb_parity_tally.sv
// tb_parity_tally: directed test-plan frames plus randomized frames for
// parity_tally (FRAME_LEN=4), checked against a frame-level reference model.
module tb_parity_tally;

    localparam int FL = 4;
    localparam int CW = $clog2(FL + 1);
    localparam int SW = $clog2(15 * FL + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    a;
    logic          even;
    logic          odd;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] even_cnt;
    logic [CW-1:0] odd_cnt;
    logic [CW-1:0] max_run;
    logic          flag_err;
`ifdef PARITY_TALLY_SUM_EN
    logic [SW-1:0] even_sum;
    logic [SW-1:0] odd_sum;
`endif

    parity_tally #(
        .FRAME_LEN (FL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .even      (even),
        .odd       (odd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .even_cnt  (even_cnt),
        .odd_cnt   (odd_cnt),
        .max_run   (max_run),
        .flag_err  (flag_err)
`ifdef PARITY_TALLY_SUM_EN
        ,
        .even_sum  (even_sum),
        .odd_sum   (odd_sum)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic       e;
        logic       o;
    } smp_t;

    typedef struct {
        int ec;
        int oc;
        int mr;
        int fe;
        int es;
        int os;
    } res_t;

    smp_t frame_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Frame-level reference: counts, longest run and flag error from the sample list
    function automatic res_t model();
        res_t r;
        int   run;
        logic prev;
        r   = '{default: 0};
        run = 0;
        prev = 1'b0;
        foreach (frame_q[i]) begin
            if (frame_q[i].e) begin
                r.ec++;
                r.es += int'(frame_q[i].a);
            end else begin
                r.oc++;
                r.os += int'(frame_q[i].a);
            end
            run  = (i == 0 || frame_q[i].e != prev) ? 1 : run + 1;
            prev = frame_q[i].e;
            if (run > r.mr) r.mr = run;
            if (frame_q[i].e == frame_q[i].o || frame_q[i].e != !frame_q[i].a[0]) r.fe = 1;
        end
        return r;
    endfunction

    // Called at a negedge: present one sample for exactly one edge, then idle `gap` cycles
    task automatic send(input logic [3:0] av, input logic ev, input logic ov, input int gap);
        smp_t s;
        check("in_ready_accum", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        a         = av;
        even      = ev;
        odd       = ov;
        out_ready = 1'($urandom_range(0, 1));
        s.a = av;
        s.e = ev;
        s.o = ov;
        frame_q.push_back(s);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 4'($urandom_range(0, 15));
        even      = 1'($urandom_range(0, 1));
        odd       = 1'($urandom_range(0, 1));
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_clean(input logic [3:0] av, input int gap);
        send(av, ~av[0], av[0], gap);
    endtask

    task automatic check_result(input string tag, input res_t r);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_in_ready"},  32'(in_ready),  32'd0);
        check({tag, "_even_cnt"},  32'(even_cnt),  32'(r.ec));
        check({tag, "_odd_cnt"},   32'(odd_cnt),   32'(r.oc));
        check({tag, "_max_run"},   32'(max_run),   32'(r.mr));
        check({tag, "_flag_err"},  32'(flag_err),  32'(r.fe));
`ifdef PARITY_TALLY_SUM_EN
        check({tag, "_even_sum"},  32'(even_sum),  32'(r.es));
        check({tag, "_odd_sum"},   32'(odd_sum),   32'(r.os));
`endif
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready"},  32'(in_ready),  32'd1);
        check({tag, "_even_cnt"},  32'(even_cnt),  32'd0);
        check({tag, "_odd_cnt"},   32'(odd_cnt),   32'd0);
        check({tag, "_max_run"},   32'(max_run),   32'd0);
        check({tag, "_flag_err"},  32'(flag_err),  32'd0);
`ifdef PARITY_TALLY_SUM_EN
        check({tag, "_even_sum"},  32'(even_sum),  32'd0);
        check({tag, "_odd_sum"},   32'(odd_sum),   32'd0);
`endif
    endtask

    // Called at the negedge right after the last accept: result must already be valid
    task automatic take_report(input string tag, input int hold);
        res_t r;
        r = model();
        check_result(tag, r);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'($urandom_range(0, 1));
            check_result({tag, "_hold"}, r);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_cleared({tag, "_clr"});
        frame_q.delete();
    endtask

    initial begin
        res_t r;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        even      = 1'b0;
        odd       = 1'b0;

        // Reset held for three cycles
        repeat (3) @(negedge clk);
        check("rst_in_ready_low", 32'(in_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_cleared("reset");

        // Basic back-to-back frame
        send_clean(4'd1, 0);
        send_clean(4'd2, 0);
        send_clean(4'd4, 0);
        send_clean(4'd6, 0);
        check("basic_even_const", 32'(even_cnt), 32'd3);
        check("basic_odd_const",  32'(odd_cnt),  32'd1);
        check("basic_run_const",  32'(max_run),  32'd3);
`ifdef PARITY_TALLY_SUM_EN
        check("basic_esum_const", 32'(even_sum), 32'd12);
        check("basic_osum_const", 32'(odd_sum),  32'd1);
`endif
        // Backpressure: five cycles held before the result is taken
        take_report("basic", 5);

        // Input gaps
        send_clean(4'd3, 2);
        send_clean(4'd5, 2);
        send_clean(4'd7, 2);
        send_clean(4'd9, 0);
        check("gaps_run_const", 32'(max_run), 32'd4);
        take_report("gaps", 1);

        // Flag error frame, then a clean frame
        send(4'd2, 1'b0, 1'b1, 0);
        send_clean(4'd1, 0);
        send_clean(4'd3, 1);
        send_clean(4'd4, 0);
        check("flag_err_const", 32'(flag_err), 32'd1);
        take_report("flagerr", 0);
        send_clean(4'd8, 0);
        send_clean(4'd10, 0);
        send_clean(4'd11, 0);
        send_clean(4'd0, 0);
        take_report("clean", 0);

        // Mid-frame reset discards the partial frame
        send_clean(4'd6, 0);
        send_clean(4'd7, 0);
        rst = 1'b1;
        #1;
        check("midrst_even_cnt",  32'(even_cnt),  32'd0);
        check("midrst_odd_cnt",   32'(odd_cnt),   32'd0);
        check("midrst_in_ready",  32'(in_ready),  32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        frame_q.delete();
        @(negedge clk);
        send_clean(4'd2, 0);
        send_clean(4'd3, 0);
        send_clean(4'd4, 0);
        send_clean(4'd5, 0);
        check("midrst_run_const", 32'(max_run), 32'd1);
        take_report("postrst", 0);

        // Reset during REPORT drops out_valid
        send_clean(4'd1, 0);
        send_clean(4'd1, 0);
        send_clean(4'd1, 0);
        send_clean(4'd1, 0);
        check("rptrst_valid_before", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("rptrst_out_valid", 32'(out_valid), 32'd0);
        check("rptrst_odd_cnt",   32'(odd_cnt),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        frame_q.delete();
        @(negedge clk);

        // Randomized frames, occasionally with corrupted flags
        for (int f = 0; f < 40; f++) begin
            for (int s = 0; s < FL; s++) begin
                logic [3:0] av;
                av = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 7) == 0) begin
                    send(av, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         (s == FL - 1) ? 0 : int'($urandom_range(0, 2)));
                end else begin
                    send_clean(av, (s == FL - 1) ? 0 : int'($urandom_range(0, 2)));
                end
            end
            r = model();
            if (r.ec > FL) check("model_sanity", 32'(r.ec), 32'(FL));
            take_report("rand", int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_parity_tally

// File: doc/parity_tally.md
# parity_tally

Frame-based tally stage that sits directly downstream of the nibble even/odd classifier. It accepts 4-bit samples together with the classifier's `even`/`odd` flags over a valid/ready handshake, and counts even and odd samples over a fixed-length frame. It also tracks the longest run of same-parity samples and checks that the flags agree with the sample LSB. At frame end it presents the registered result on a second valid/ready handshake to the statistics/reporting logic.

## Interface
- `FRAME_LEN`, default 16: samples per frame; legal range ≥ 2.
- `CNT_W`, default `$clog2(FRAME_LEN+1)`: derived localparam, not overridable; width of all count outputs.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream sample valid.
- `in_ready`  out  1  block accepts a sample this cycle.
- `a`  in  4  sample value; the same nibble drives the classifier.
- `even`  in  1  classifier even flag for `a`, combinational, same cycle.
- `odd`  in  1  classifier odd flag for `a`, combinational, same cycle.
- `out_valid`  out  1  frame result valid.
- `out_ready`  in  1  downstream accepts the result.
- `even_cnt`  out  CNT_W  number of even samples in the frame.
- `odd_cnt`  out  CNT_W  number of odd samples in the frame.
- `max_run`  out  CNT_W  longest run of consecutive same-parity samples.
- `flag_err`  out  1  at least one accepted sample had inconsistent flags.

## Operation
- The FSM has two states, ACCUM and REPORT. Reset state is ACCUM.
- **ACCUM**
  - `in_ready` is 1 and `out_valid` is 0.
  - A sample is accepted when `in_valid` and `in_ready` are both 1.
  - Parity is taken from `even`: `even`=1 increments `even_cnt`; otherwise `odd_cnt` increments.
  - Run length:
    - It is set to 1 on the first sample of a frame, or when parity differs from the previous accepted sample.
    - Otherwise it increments.
    - `max_run` is updated to max(`max_run`, new run length).
  - `flag_err` sets (sticky within the frame) if an accepted sample has `even`==`odd`, or `even` != ~`a[0]`.
  - A sample index counts accepts. When the accept with index FRAME_LEN-1 occurs, the FSM moves to REPORT.
- **REPORT**
  - `in_ready` is 0 and `out_valid` is 1.
  - All result outputs are held stable until `out_ready`=1.
  - When `out_ready`=1: the counts, run, index and `flag_err` clear to 0, and the FSM returns to ACCUM.
- Counts never exceed FRAME_LEN, so there is no wrap or overflow.
- Reset values: `out_valid`=0, `even_cnt`=`odd_cnt`=`max_run`=0, `flag_err`=0, index 0, run 0.
- `in_ready`=0 while `rst` is asserted.
- Result outputs are the live registers, so their values are meaningful only while `out_valid`=1.

## Timing
- `in_ready` and `out_valid` are decoded from the registered state only; there is no combinational path from `in_valid`/`out_ready`.
- Latency: the final accept at edge t gives `out_valid`=1 from t+1.
- The handshake in REPORT completes at edge t'. At t'+1, `in_ready`=1 and the counts are 0.
- Minimum frame period is FRAME_LEN+1 cycles.
- `in_valid` may drop at any time in ACCUM. Idle cycles do not affect run tracking.
- `rst` asserted mid-frame or mid-REPORT immediately clears everything and drops `out_valid`. The partial frame is discarded.
- `out_ready` has no effect in ACCUM.

## Configuration
- `PARITY_TALLY_SUM_EN` defined:
  - Adds outputs `even_sum` and `odd_sum`, each `$clog2(15*FRAME_LEN+1)` bits wide.
  - Each accepted sample's `a` is added to the sum selected by its parity.
  - Both sums clear and hold exactly like the counts.
- Undefined: the ports and registers are absent, and behaviour is otherwise identical.

## Structure
- Package `parity_tally_pkg` holds:
  - the state enum typedef (ACCUM, REPORT);
  - the `FRAME_LEN` default constant;
  - the nibble width constant (4).
- One sub-module, `run_tracker`. It takes the accept strobe, parity bit and frame-start flag, and returns the registered current run and `max_run`.

## Test plan
All tests use FRAME_LEN=4.
1. **Reset:** assert `rst` for 3 cycles, then release → `out_valid`=0, all counts 0, `flag_err`=0; `in_ready`=1 on the first cycle after release.
2. **Basic frame:** back-to-back samples 1,2,4,6 with correct flags → one cycle after the 4th accept, `out_valid`=1, `even_cnt`=3, `odd_cnt`=1, `max_run`=3, `flag_err`=0.
3. **Backpressure:** hold `out_ready`=0 for 5 cycles in REPORT → `out_valid` and the values stay stable and `in_ready`=0. Then `out_ready`=1 → next cycle counts are 0 and `in_ready`=1.
4. **Input gaps:** samples 3,5,7,9 with 2 idle cycles between each → `odd_cnt`=4, `even_cnt`=0, `max_run`=4.
5. **Flag error:** a frame containing `a`=2 with `even`=0, `odd`=1 → `flag_err`=1 in the report; the next frame with clean flags reports `flag_err`=0.
6. **Mid-frame reset:** `rst` after 2 accepts → counts are 0 immediately. The following 4 samples 2,3,4,5 report `even_cnt`=2, `odd_cnt`=2, `max_run`=1. With `PARITY_TALLY_SUM_EN` defined, test 2 also reports `even_sum`=12 and `odd_sum`=1.
